// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: widths, control encodings and the
// packed decode-to-execute bundle layout.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 3;

    // Result select for the writeback mux
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    // ALU operation encodings
    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // Immediate format selected by the sign extender
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    // Decode-to-execute bundle, MSB first
    typedef struct packed {
        logic [XLEN-1:0]   ext_imm;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic [ALUC_W-1:0] alu_control;
        logic              alu_src;
    } idex_t;

    localparam int IDEX_W = $bits(idex_t);

    // Skid-buffer occupancy. Bit 0 = main entry valid, bit 1 = skid entry
    // valid, so valid_e and ready_d come straight off state flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset, flush clear, load enable.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset and flush both clear; otherwise load when enabled, else hold
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute boundary built as a two-entry skid buffer. The main
// entry drives the execute outputs; the skid entry absorbs the one bundle
// that may arrive while execute stalls, so ready_d is a flop and never
// depends combinationally on ready_e.
module id_ex_skid_reg
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              valid_d,
    output logic              ready_d,
    input  logic              FlushE,

    input  logic [XLEN-1:0]   ExtImmD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,

    output logic              valid_e,
    input  logic              ready_e,

    output logic [XLEN-1:0]   ExtImmE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [ALUC_W-1:0] ALUControlE
);

    skid_state_e state, state_nxt;

    idex_t in_bundle, main_q, skid_q, main_d;
    logic  push, pop;
    logic  main_en, skid_en, main_from_skid;

    // Pack the decode fields into the bundle layout
    always_comb begin
        in_bundle             = '0;
        in_bundle.ext_imm     = ExtImmD;
        in_bundle.rd1         = RD1D;
        in_bundle.rd2         = RD2D;
        in_bundle.pc          = PCD;
        in_bundle.pc_plus4    = PCPlus4D;
        in_bundle.rs1         = Rs1D;
        in_bundle.rs2         = Rs2D;
        in_bundle.rd          = RdD;
        in_bundle.reg_write   = RegWriteD;
        in_bundle.result_src  = ResultSrcD;
        in_bundle.mem_write   = MemWriteD;
        in_bundle.jump        = JumpD;
        in_bundle.branch      = BranchD;
        in_bundle.alu_control = ALUControlD;
        in_bundle.alu_src     = ALUSrcD;
    end

    assign push = valid_d & ready_d;
    assign pop  = valid_e & ready_e;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next occupancy: flush empties everything and drops the same-cycle push
    always_comb begin
        state_nxt = state;
        if (FlushE) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: state_nxt = push ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (pop) state_nxt = push ? ST_ONE  : ST_EMPTY;
                    else     state_nxt = push ? ST_FULL : ST_ONE;
                end
                // ready_d is low here, so no push can coincide with FULL
                ST_FULL:  state_nxt = pop ? ST_ONE : ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs and entry load controls decoded from occupancy
    always_comb begin
        valid_e        = state[0];
        ready_d        = ~state[1];
        main_from_skid = 1'b0;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        unique case (state)
            ST_EMPTY: main_en = push;
            ST_ONE: begin
                main_en = push & ready_e;
                skid_en = push & ~ready_e;
            end
            ST_FULL: begin
                // Older skid bundle moves up before anything newer
                main_from_skid = 1'b1;
                main_en        = ready_e;
            end
            default: ;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_bundle;

    pipe_reg #(.W(IDEX_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .clr (FlushE),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_reg #(.W(IDEX_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .clr (FlushE),
        .d   (in_bundle),
        .q   (skid_q)
    );

    // Drive execute fields; side-effecting controls are masked in bubbles
    always_comb begin
        ExtImmE     = main_q.ext_imm;
        RD1E        = main_q.rd1;
        RD2E        = main_q.rd2;
        PCE         = main_q.pc;
        PCPlus4E    = main_q.pc_plus4;
        Rs1E        = main_q.rs1;
        Rs2E        = main_q.rs2;
        RdE         = main_q.rd;
        ResultSrcE  = main_q.result_src;
        ALUControlE = main_q.alu_control;
        ALUSrcE     = main_q.alu_src;
        RegWriteE   = main_q.reg_write & valid_e;
        MemWriteE   = main_q.mem_write & valid_e;
        JumpE       = main_q.jump      & valid_e;
        BranchE     = main_q.branch    & valid_e;
    end

endmodule
